// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Desc     : PS/2 host-to-device command transmitter driving open-drain pads
//            through output enables. Optional retry-once: PS2_TX_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] tx_err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int c_inh_w = $clog2(INHIBIT_CYCLES);
  localparam int c_to_w  = $clog2(TIMEOUT_CYCLES);
  localparam int c_flt_w = $clog2(FILTER_LEN);

  localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_flt_w-1:0] c_flt_last = c_flt_w'(FILTER_LEN - 1);

  generate
    if (CLK_FREQ_HZ < 1 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 2) begin : g_param_check
      $error("ps2_host_tx: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_INHIBIT   = 2'd1,
    S_XFER      = 2'd2,
    S_WAIT_IDLE = 2'd3
  } state_t;

  state_t               r_state, w_next;
  logic                 r_armed;
  logic                 r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic                 r_clk_flt, r_clk_flt_d;
  logic [c_flt_w-1:0]   r_flt_cnt;
  logic [c_inh_w-1:0]   r_inh_cnt;
  logic [c_to_w-1:0]    r_to_cnt;
  logic [3:0]           r_n;
  logic [7:0]           r_data;
  logic                 r_par;
  logic                 r_done, r_err;
  logic [1:0]           r_err_code;
`ifdef PS2_TX_RETRY_EN
  logic                 r_retried;
  logic                 w_retry;
`endif

  logic                 w_fall, w_edge, w_to_clr, w_timeout;
  logic                 w_accept, w_clk_oe, w_data_oe;
  logic                 w_fail, w_done, w_err;
  logic [1:0]           w_fail_code;

  // Line conditioning: 2-FF synchronisers, then a run-length filter on ps2_clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_clk_flt   <= 1'b1;
      r_clk_flt_d <= 1'b1;
      r_flt_cnt   <= '0;
    end else begin
      r_clk_s1    <= ps2_clk_i;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_data_i;
      r_dat_s2    <= r_dat_s1;
      r_clk_flt_d <= r_clk_flt;
      if (r_clk_s2 == r_clk_flt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == c_flt_last) begin
        r_clk_flt <= r_clk_s2;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  assign w_fall = r_clk_flt_d & ~r_clk_flt;
  assign w_edge = r_clk_flt_d ^ r_clk_flt;

  // Before the first device edge the only rising edge is our own clock release,
  // so it must not restart the no-activity timer.
  assign w_to_clr  = (r_state == S_XFER && r_n == 4'd0) ? w_fall : w_edge;
  assign w_timeout = (r_to_cnt == c_to_last) && !w_to_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_n        <= '0;
      r_data     <= '0;
      r_par      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
`ifdef PS2_TX_RETRY_EN
      r_retried  <= 1'b0;
`endif
    end else begin
      r_state    <= w_next;
      r_armed    <= 1'b1;
      r_done     <= w_done;
      r_err      <= w_err;
      r_err_code <= w_err ? w_fail_code : 2'b00;

      if (w_accept) begin
        r_data <= tx_data;
        r_par  <= ~^tx_data;
      end

      if (r_state == S_INHIBIT && w_next == S_INHIBIT) r_inh_cnt <= r_inh_cnt + 1'b1;
      else                                           r_inh_cnt <= '0;

      if (r_state == S_XFER || r_state == S_WAIT_IDLE)
        r_to_cnt <= w_to_clr ? '0 : r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;

      if (r_state != S_XFER) r_n <= '0;
      else if (w_fall)       r_n <= r_n + 4'd1;

`ifdef PS2_TX_RETRY_EN
      if (w_accept)     r_retried <= 1'b0;
      else if (w_retry) r_retried <= 1'b1;
`endif
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_clk_oe    = 1'b0;
    w_data_oe   = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = 2'b00;
    w_done      = 1'b0;
    w_err       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    w_retry     = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (tx_valid && r_armed) begin
          w_accept = 1'b1;
          w_next   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_clk_oe = 1'b1;
        if (r_inh_cnt == c_inh_last) begin
          w_data_oe = 1'b1;
          w_next    = S_XFER;
        end
      end
      S_XFER: begin
        // Open-drain: enable asserted drives a 0 onto the line.
        case (r_n)
          4'd0:    w_data_oe = 1'b1;
          4'd1:    w_data_oe = ~r_data[0];
          4'd2:    w_data_oe = ~r_data[1];
          4'd3:    w_data_oe = ~r_data[2];
          4'd4:    w_data_oe = ~r_data[3];
          4'd5:    w_data_oe = ~r_data[4];
          4'd6:    w_data_oe = ~r_data[5];
          4'd7:    w_data_oe = ~r_data[6];
          4'd8:    w_data_oe = ~r_data[7];
          4'd9:    w_data_oe = ~r_par;
          default: w_data_oe = 1'b0;
        endcase
        if (w_fall && r_n == 4'd10) begin
          if (r_dat_s2) begin
            w_fail      = 1'b1;
            w_fail_code = 2'b10;
          end else begin
            w_next = S_WAIT_IDLE;
          end
        end else if (w_timeout) begin
          w_fail      = 1'b1;
          w_fail_code = 2'b01;
        end
      end
      S_WAIT_IDLE: begin
        if (r_clk_flt && r_dat_s2) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (w_timeout) begin
          w_fail      = 1'b1;
          w_fail_code = 2'b01;
        end
      end
      default: w_next = S_IDLE;
    endcase

    if (w_fail) begin
`ifdef PS2_TX_RETRY_EN
      if (!r_retried) begin
        w_retry = 1'b1;
        w_next  = S_INHIBIT;
      end else begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
`else
      w_err  = 1'b1;
      w_next = S_IDLE;
`endif
    end
  end

  assign tx_ready    = (r_state == S_IDLE) && r_armed;
  assign tx_busy     = (r_state != S_IDLE);
  assign tx_done     = r_done;
  assign tx_err      = r_err;
  assign tx_err_code = r_err_code;
  assign ps2_clk_oe  = w_clk_oe;
  assign ps2_data_oe = w_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Desc     : Self-checking bench for ps2_host_tx with a PS/2 device model and
//            frame/outcome scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TO  = 3000;
  localparam int FLT = 4;
  localparam int H   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] tx_err_code;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  bit bitq[$];
  int outq[$];

  int   m_exp, m_got;
  logic m_prev_busy = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ   (100_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .tx_err_code(tx_err_code),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Outcome scoreboard: 0 = done, 1 = timeout, 2 = NACK.
  always @(posedge clk) begin
    #1;
    if (tx_done === 1'b1 && tx_err === 1'b1) begin
      n_checks++;
      $display("FAIL done_err_overlap got=both_high exp=exclusive");
    end else if (tx_done === 1'b1 || tx_err === 1'b1) begin
      m_got = (tx_done === 1'b1) ? 0 : int'(tx_err_code);
      n_checks++;
      if (outq.size() == 0) begin
        $display("FAIL unexpected_outcome got=%0d exp=none", m_got);
      end else begin
        m_exp = outq.pop_front();
        if (m_got !== m_exp) $display("FAIL outcome got=%0d exp=%0d", m_got, m_exp);
        else n_pass++;
      end
      n_checks++;
      if (tx_err === 1'b1) begin
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
          $display("FAIL err_release got=%0b%0b exp=00", ps2_clk_oe, ps2_data_oe);
        else n_pass++;
      end else begin
        if (tx_busy !== 1'b0 || m_prev_busy !== 1'b1)
          $display("FAIL busy_fall_with_done got=%0b prev=%0b exp=0 prev=1", tx_busy, m_prev_busy);
        else n_pass++;
      end
    end
    m_prev_busy = tx_busy;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    bitq.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bitq.push_back(b[i]);
      if (b[i]) ones++;
    end
    bitq.push_back((ones % 2) == 0);
    bitq.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 500) begin step(); t++; end
    if (t >= 500) begin
      n_checks++;
      $display("FAIL ready_wait got=%0b exp=1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle_and_outcome(input string name);
    int t;
    t = 0;
    while (tx_busy !== 1'b0 && t < 5000) begin step(); t++; end
    step();
    step();
    n_checks++;
    if (outq.size() != 0) $display("FAIL %s_outcome_seen got=%0d_pending exp=0_pending", name, outq.size());
    else n_pass++;
  endtask

  // Device model: observes host request, clocks out `edges` edges, samples the
  // host's bit before each falling edge, and optionally ACKs at edge 11.
  task automatic dev_frame(input int edges, input bit ack, input bit glitch,
                           output int hold, output int drise);
    int t;
    bit b;
    hold  = 0;
    drise = 0;
    t     = 0;
    while (ps2_clk_oe !== 1'b1 && t < 2000) begin step(); t++; end
    while (ps2_clk_oe === 1'b1 && t < 2000) begin
      hold++;
      if (ps2_data_oe === 1'b1 && drise == 0) drise = hold;
      step();
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      $display("FAIL inhibit_wait got=timeout exp=request");
      return;
    end
    repeat (20) step();
    for (int k = 1; k <= edges; k++) begin
      for (int c = 0; c < H; c++) begin
        if (glitch && k == 4 && c == 10) dev_clk_low = 1'b1;
        if (glitch && k == 4 && c == 12) dev_clk_low = 1'b0;
        step();
      end
      if (bitq.size() > 0) begin
        b = bitq.pop_front();
        n_checks++;
        if (ps2_data_i !== b) $display("FAIL frame_bit k=%0d got=%0b exp=%0b", k, ps2_data_i, b);
        else n_pass++;
      end
      if (k == 11 && ack) dev_data_low = 1'b1;
      step();
      step();
      dev_clk_low = 1'b1;
      repeat (H) step();
      dev_clk_low = 1'b0;
    end
    repeat (H) step();
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe, tx_err_code} !== 8'h00)
      $display("FAIL reset_outputs got=%b exp=00000000",
               {tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe, tx_err_code});
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if (tx_ready !== 1'b1) $display("FAIL reset_ready_rise got=%0b exp=1", tx_ready);
    else n_pass++;
  endtask

  task automatic test_send_ed();
    int hold, drise;
    expect_frame(8'hED);
    outq.push_back(0);
    send(8'hED);
    dev_frame(11, 1'b1, 1'b0, hold, drise);
    wait_idle_and_outcome("send_ed");
  endtask

  task automatic test_ff_inhibit();
    int hold, drise;
    expect_frame(8'hFF);
    outq.push_back(0);
    send(8'hFF);
    dev_frame(11, 1'b1, 1'b0, hold, drise);
    n_checks++;
    if (hold !== INH) $display("FAIL inhibit_len got=%0d exp=%0d", hold, INH);
    else n_pass++;
    n_checks++;
    if (drise !== INH) $display("FAIL start_bit_cycle got=%0d exp=%0d", drise, INH);
    else n_pass++;
    wait_idle_and_outcome("ff");
  endtask

  task automatic test_timeout();
    int t, cnt;
    outq.push_back(1);
    send(8'hED);
    t = 0;
    while (ps2_clk_oe === 1'b1 && t < 1000) begin step(); t++; end
    cnt = 0;
    while (tx_err !== 1'b1 && cnt < TO + 100) begin step(); cnt++; end
    n_checks++;
    if (cnt !== TO) $display("FAIL timeout_latency got=%0d exp=%0d", cnt, TO);
    else n_pass++;
    wait_idle_and_outcome("timeout");
  endtask

  task automatic test_nack();
    int hold, drise, seen;
    expect_frame(8'hED);
    outq.push_back(2);
    send(8'hED);
    dev_frame(11, 1'b0, 1'b0, hold, drise);
`ifdef PS2_TX_RETRY_EN
    expect_frame(8'hED);
    dev_frame(11, 1'b0, 1'b0, hold, drise);
    n_checks++;
    if (hold < 1) $display("FAIL retry_inhibit got=%0d exp=>0", hold);
    else n_pass++;
`endif
    wait_idle_and_outcome("nack");
    seen = 0;
    repeat (150) begin
      if (ps2_clk_oe === 1'b1) seen++;
      step();
    end
    n_checks++;
    if (seen !== 0) $display("FAIL nack_no_further_inhibit got=%0d exp=0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int hold, drise;
    expect_frame(8'h00);
    send(8'h00);
    dev_frame(5, 1'b0, 1'b0, hold, drise);
    bitq.delete();
    n_checks++;
    if (ps2_data_oe !== 1'b1) $display("FAIL midframe_data_oe got=%0b exp=1", ps2_data_oe);
    else n_pass++;
    rst = 1'b1;
    step();
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy} !== 4'b0000)
      $display("FAIL midframe_reset_release got=%b exp=0000", {ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy});
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if (tx_ready !== 1'b1) $display("FAIL midframe_ready_after got=%0b exp=1", tx_ready);
    else n_pass++;
    repeat (50) step();
  endtask

  task automatic test_ignore_valid_glitch();
    int hold, drise, seen;
    expect_frame(8'hF4);
    outq.push_back(0);
    send(8'hF4);
    fork
      dev_frame(11, 1'b1, 1'b1, hold, drise);
      begin
        repeat (300) step();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        repeat (4) step();
        tx_valid = 1'b0;
      end
    join
    wait_idle_and_outcome("ignore_valid");
    seen = 0;
    repeat (200) begin
      if (ps2_clk_oe === 1'b1) seen++;
      step();
    end
    n_checks++;
    if (seen !== 0) $display("FAIL busy_valid_ignored got=%0d exp=0", seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_ff_inhibit();
    test_timeout();
    test_nack();
    test_reset_midframe();
    test_ignore_valid_glitch();
    n_checks++;
    if (bitq.size() != 0) $display("FAIL frame_queue_drained got=%0d exp=0", bitq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
